// File: rtl/uart_rx_simplified.sv
// ============================================================================
// uart_rx_simplified
// ----------------------------------------------------------------------------
// Receive side of the simplified UART link. Deserialises frames produced by the
// paired simplified transmitter and hands each byte to the consumer logic with
// a one-cycle valid strobe. A frame whose stop bit is wrong is reported with a
// one-cycle framing-error strobe. A start bit that does not survive until its
// mid-bit confirmation point is treated as a glitch and silently dropped.
//
// Line format (matches the transmitter):
//   idle = 0, start bit = 1, DATA_BITS data bits LSB first, stop bit = 0,
//   every bit lasts CLKS_PER_BIT clock cycles.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 1, default 1)
//   DATA_BITS     payload bits per frame (>= 2, default 8)
//
// Ports:
//   clk        in   1          single clock, rising edge
//   rst        in   1          synchronous, active-low reset
//   rx         in   1          serial line
//   data       out  DATA_BITS  last correctly received byte, held until the
//                              next good frame
//   valid      out  1          one-cycle pulse, data has just been updated
//   frame_err  out  1          one-cycle pulse, stop bit was wrong
//   busy       out  1          high whenever the receiver is not in IDLE
//
// Configuration macro:
//   UART_RX_SYNC_EN  when defined, rx passes through a two-flop synchronizer
//                    before the FSM, adding two cycles to every response.
//                    Leave it undefined only when rx comes from the same
//                    clock domain.
// ============================================================================
module uart_rx_simplified #(
    parameter int CLKS_PER_BIT = 1,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    // Offset from the detected start edge to the middle of each bit.
    localparam int HALF  = (CLKS_PER_BIT - 1) / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int IDX_W = $clog2(DATA_BITS) + 1;

    // Terminal counts for the bit-period counter and the bit index. The
    // start-confirmation terminal count is only meaningful when HALF > 0;
    // with HALF = 0 the confirmation happens in IDLE itself.
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((HALF > 0) ? (HALF - 1) : 0);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_LOW
    } state_t;

    state_t                 state;
    logic   [CNT_W-1:0]     bit_cnt;
    logic   [IDX_W-1:0]     bit_idx;
    logic   [DATA_BITS-1:0] shift_reg;
    logic                   rx_s;

`ifdef UART_RX_SYNC_EN
    logic sync_q1;
    logic sync_q2;

    // Two-flop synchronizer for an asynchronous serial line. Both flops
    // clear on reset so a reset never leaves a stale 1 that could be taken
    // for a start bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= rx;
            sync_q2 <= sync_q1;
        end
    end

    assign rx_s = sync_q2;
`else
    // Same-domain line: sample it directly, no added latency.
    assign rx_s = rx;
`endif

    // Receiver FSM. All outputs are registered here so valid/frame_err
    // appear in the cycle after the stop-bit sample and data changes in
    // exactly the same cycle as valid.
    //
    // The bit-period counter restarts on every state entry and after every
    // data-bit sample, so the n-th data bit is always sampled CLKS_PER_BIT
    // cycles after the previous one, starting from the start-bit midpoint.
    //
    // Data bits are shifted in from the top; after DATA_BITS shifts the
    // first (least significant) bit has arrived at bit 0.
    //
    // After a framing error the line may still be sitting at 1. WAIT_LOW
    // holds the FSM until the line has gone back to idle, so that level is
    // not mistaken for the start bit of a new frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (rx_s) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        busy    <= 1'b1;
                        if (HALF == 0) begin
                            state <= DATA;
                        end else begin
                            state <= START;
                        end
                    end
                end

                START: begin
                    if (bit_cnt == HALF_LAST) begin
                        bit_cnt <= '0;
                        if (rx_s) begin
                            state <= DATA;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_ONE;
                    end
                end

                DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt   <= '0;
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        if (bit_idx == IDX_LAST) begin
                            bit_idx <= '0;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + IDX_ONE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_ONE;
                    end
                end

                STOP: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        if (!rx_s) begin
                            data  <= shift_reg;
                            valid <= 1'b1;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_LOW;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_ONE;
                    end
                end

                WAIT_LOW: begin
                    if (!rx_s) begin
                        bit_cnt <= '0;
                        state   <= IDLE;
                        busy    <= 1'b0;
                    end
                end

                default: begin
                    bit_cnt <= '0;
                    bit_idx <= '0;
                    state   <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_simplified.sv
// ============================================================================
// tb_uart_rx_simplified
// ----------------------------------------------------------------------------
// Self-checking bench for uart_rx_simplified. One receiver runs at one clock
// per bit (the transmitter's timing), a second one at four clocks per bit is
// used for start-glitch rejection. Every frame that should produce a strobe
// pushes its expected kind, byte and arrival cycle onto a scoreboard; a
// monitor pops and compares whenever the receiver strobes.
// ============================================================================
module tb_uart_rx_simplified;

`ifdef UART_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    typedef struct {
        logic       is_err;
        logic [7:0] data;
        int         at;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rx4;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;
    logic [7:0] data4;
    logic       valid4;
    logic       frame_err4;
    logic       busy4;

    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    exp_t       sb[$];
    logic [7:0] last_good = 8'h00;

    uart_rx_simplified #(.CLKS_PER_BIT(1), .DATA_BITS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    uart_rx_simplified #(.CLKS_PER_BIT(4), .DATA_BITS(8)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx4),
        .data      (data4),
        .valid     (valid4),
        .frame_err (frame_err4),
        .busy      (busy4)
    );

    // Free-running clock and a cycle counter used to time-stamp strobes.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // One comparison: counts it, and on a mismatch counts the failure and
    // reports tag, observed and expected values.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Holds the serial line at one level for one bit period.
    task automatic driveBit(input logic b);
        rx = b;
        @(posedge clk);
        #1;
    endtask

    // Sends one full frame on the 1-clock-per-bit line and records what the
    // receiver should report and when: the strobe comes 10 cycles after the
    // start bit is first on the line, plus the synchronizer latency.
    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
        exp_t e;
        e.is_err = stop_bit;
        e.data   = stop_bit ? last_good : b;
        e.at     = cyc + 10 + LAT;
        sb.push_back(e);
        if (!stop_bit) last_good = b;
        driveBit(1'b1);
        for (int i = 0; i < 8; i++) driveBit(b[i]);
        driveBit(stop_bit);
    endtask

    // Waits a bounded number of cycles for every expected strobe to arrive.
    task automatic waitDrain(input string tag);
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput(tag, sb.size(), 0);
    endtask

    // Strobe monitor: every valid/frame_err must match the head of the
    // scoreboard in kind, cycle and byte; the slow receiver must never strobe.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst === 1'b1) begin
            if (valid || frame_err) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_pulse", {30'd0, valid, frame_err}, 0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("pulse_kind", {30'd0, valid, frame_err},
                                e.is_err ? 32'd1 : 32'd2);
                    checkOutput("pulse_cycle", cyc, e.at);
                    checkOutput("pulse_data", {24'd0, data}, {24'd0, e.data});
                end
            end
            if (valid4 || frame_err4) begin
                checkOutput("glitch_pulse", {30'd0, valid4, frame_err4}, 0);
            end
        end
    end

    // Hard stop if something hangs the directed sequence.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        rst = 1'b0;
        rx  = 1'b0;
        rx4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_data",      {24'd0, data}, 0);
        checkOutput("reset_valid",     {31'd0, valid}, 0);
        checkOutput("reset_frame_err", {31'd0, frame_err}, 0);
        checkOutput("reset_busy",      {31'd0, busy}, 0);
        checkOutput("reset_busy4",     {31'd0, busy4}, 0);
        rst = 1'b1;
        repeat (3) driveBit(1'b0);

        $display("[TB] good frame 0xA5");
        applyStimulus(8'hA5, 1'b0);
        rx = 1'b0;
        waitDrain("drain_good");
        checkOutput("good_data", {24'd0, data}, 32'hA5);
        checkOutput("good_busy_idle", {31'd0, busy}, 0);

        $display("[TB] framing error 0x3C");
        applyStimulus(8'h3C, 1'b1);
        repeat (5) driveBit(1'b1);
        checkOutput("wait_low_busy", {31'd0, busy}, 1);
        repeat (LAT + 2) driveBit(1'b0);
        checkOutput("after_wait_low_busy", {31'd0, busy}, 0);
        repeat (4) driveBit(1'b0);
        checkOutput("no_restart_busy", {31'd0, busy}, 0);
        waitDrain("drain_ferr");
        checkOutput("ferr_data_hold", {24'd0, data}, 32'hA5);

        $display("[TB] start glitch at 4 clocks per bit");
        rx4 = 1'b1;
        @(posedge clk);
        #1;
        rx4 = 1'b0;
        repeat (LAT) begin
            @(posedge clk);
            #1;
        end
        checkOutput("glitch_busy_high", {31'd0, busy4}, 1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checkOutput("glitch_busy_low", {31'd0, busy4}, 0);
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        checkOutput("glitch_stays_idle", {31'd0, busy4}, 0);

        $display("[TB] back-to-back 0x01, 0xFF");
        applyStimulus(8'h01, 1'b0);
        driveBit(1'b0);
        applyStimulus(8'hFF, 1'b0);
        rx = 1'b0;
        waitDrain("drain_b2b");
        checkOutput("b2b_data", {24'd0, data}, 32'hFF);

        $display("[TB] reset during 0x55, then 0x0F");
        driveBit(1'b1);
        for (int i = 0; i < 4; i++) driveBit(1'b1 & (8'h55 >> i));
        rx  = 1'b1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        rx  = 1'b0;
        checkOutput("midreset_data",      {24'd0, data}, 0);
        checkOutput("midreset_valid",     {31'd0, valid}, 0);
        checkOutput("midreset_frame_err", {31'd0, frame_err}, 0);
        checkOutput("midreset_busy",      {31'd0, busy}, 0);
        repeat (12) driveBit(1'b0);
        checkOutput("midreset_quiet", {31'd0, busy}, 0);
        applyStimulus(8'h0F, 1'b0);
        rx = 1'b0;
        waitDrain("drain_after_reset");
        checkOutput("after_reset_data", {24'd0, data}, 32'h0F);

        repeat (5) driveBit(1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_simplified.md
# uart_rx_simplified

- Receive side of the simplified UART link.
- Deserialises frames produced by the simplified transmitter and delivers each byte with a one-cycle valid strobe.
- Flags malformed frames (framing error) and rejects start-bit glitches.
- Sits between the serial line input and the byte-consumer logic, in the same clock domain as the transmitter it pairs with.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 1: clock cycles per serial bit; must be ≥1. The default of 1 matches the transmitter's one-bit-per-clock timing.
- `DATA_BITS`, default 8: payload bits per frame.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `rx`  in  1  serial line.
- `data`  out  DATA_BITS  last correctly received byte; holds until the next good frame.
- `valid`  out  1  one-cycle pulse; `data` is new.
- `frame_err`  out  1  one-cycle pulse; stop bit was wrong.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
Line format, matching the transmitter:
- Idle level is 0.
- Start bit is 1.
- DATA_BITS data bits follow, LSB first.
- Stop bit is 0.
- Each bit lasts CLKS_PER_BIT cycles.

Sampling:
- The internal line signal `rx_s` is `rx`, or `rx` after the synchronizer (see Configuration).
- HALF = (CLKS_PER_BIT-1)/2, integer division.
- Cycle d is the first cycle in IDLE with `rx_s`=1.

FSM states and transitions:
- IDLE: if `rx_s`=1, go to START with the bit counter cleared.
- START: confirm the start bit at d+HALF.
  - If `rx_s`=0 at that sample, treat it as a glitch and return to IDLE with no output.
  - If `rx_s`=1, go to DATA.
  - When HALF=0, confirmation happens in cycle d itself (IDLE goes straight to DATA).
- DATA: sample bit n (n=0..DATA_BITS-1) at d+HALF+(n+1)·CLKS_PER_BIT into shift register bit n. After the last bit, go to STOP.
- STOP: sample at d+HALF+(DATA_BITS+1)·CLKS_PER_BIT.
  - If `rx_s`=0 (good frame), load `data`, pulse `valid`, go to IDLE.
  - If `rx_s`=1, pulse `frame_err`, leave `data` unchanged, go to WAIT_LOW.
- WAIT_LOW: stay until `rx_s`=0, then go to IDLE. This prevents a stuck-high line from being re-read as a start bit.

Counters:
- The bit-period counter is $clog2(CLKS_PER_BIT)+1 bits wide.
- The bit index is $clog2(DATA_BITS)+1 bits wide.
- Both clear on every state entry and never wrap mid-frame.

## Timing
- Reset values: `data`=0, `valid`=0, `frame_err`=0, `busy`=0, FSM=IDLE, counters=0, synchronizer flops=0.
- `rst` low mid-frame aborts the frame immediately. No `valid` or `frame_err` is produced for the aborted frame.
- `valid` or `frame_err` is asserted in the cycle after the stop sample, for exactly one cycle. `data` updates in the same cycle as `valid`.
- With CLKS_PER_BIT=1 and no synchronizer:
  - start detected at d
  - data bits sampled d+1..d+8
  - stop sampled at d+9
  - `valid` high at d+10
- Back-to-back frames:
  - The FSM is in IDLE in the cycle after a good stop sample, so a new start can be detected there.
  - The transmitter's minimum gap (one idle-0 cycle) is therefore always accepted.
- `busy` is high from cycle d+1 until the FSM returns to IDLE, including WAIT_LOW.
- A 1 on `rx_s` exactly in the stop-sample cycle is a framing error, even if the line returns to 0 on the next cycle.

## Configuration
Macro `UART_RX_SYNC_EN`:
- Defined: `rx` passes through a two-flop synchronizer (reset to 0) before the FSM. All response times shift by +2 cycles (`valid` at d+12 for CLKS_PER_BIT=1, d measured on `rx`).
- Undefined: `rx_s`=`rx` directly, with no added latency. Use this only when `rx` is driven from the same clock domain.

## Test plan
- Good frame, CLKS_PER_BIT=1, no sync: drive 0x A5 as 1,1,0,1,0,0,1,0,1,0 from cycle d.
  - Required: `valid`=1 for one cycle at d+10, `data`=0xA5, `frame_err`=0 throughout.
- Framing error: frame 0x3C with stop bit driven 1, then line held 1 for 5 cycles, then 0.
  - Required: `frame_err` pulses at d+10, `data` keeps its previous value.
  - Required: no new start is detected until after the line returns to 0.
- Glitch rejection, CLKS_PER_BIT=4: `rx`=1 for 1 cycle, then 0.
  - Required: FSM returns to IDLE, no `valid`, no `frame_err`, `busy` drops within 2 cycles.
- Back-to-back: frames 0x01 and 0xFF separated by a single 0 cycle.
  - Required: two `valid` pulses 11 cycles apart, carrying 0x01 then 0xFF.
- Reset mid-frame: assert `rst`=0 for 1 cycle during data bit 4 of 0x55, then send a full frame 0x0F.
  - Required: all outputs are 0 after reset, nothing is reported for 0x55, and 0x0F is received correctly.
- With `UART_RX_SYNC_EN` defined: rerun the good-frame case.
  - Required: `valid` at d+12, `data`=0xA5.
